seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_display_scan.sv | 122 ++++++++++++
 tb/tb_seg_display_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Six-digit multiplexed 7-segment scanner with frame latching, inter-slot blanking and edit-field blink.
// Latency: an/seg/dp are registered and reflect the previous cycle's scan state; free-running, no backpressure.
module seg_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       switch,
    input  logic [3:0] hrstens,
    input  logic [3:0] hrsones,
    input  logic [3:0] mintens,
    input  logic [3:0] minones,
    input  logic [3:0] sectens,
    input  logic [3:0] secones,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [2:0]        slot_q, slot_d;
    logic [5:0][3:0]   frame_q, frame_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_vis_q, blink_vis_d;
    logic [2:0]        sm_prev_q;
    logic [7:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    logic              ref_tc, in_blank, edit_hit, edit_blank;
    logic [2:0]        sm_now;
    logic [3:0]        digit;
    logic [6:0]        dec;

    always_comb begin
        ref_tc    = (ref_cnt_q == RW'(REFRESH_DIV - 1));
        ref_cnt_d = ref_tc ? '0 : ref_cnt_q + RW'(1);
        slot_d    = slot_q;
        if (ref_tc) begin
            slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end
        // Whole frame is captured at once on the 5->0 wrap so a scan never mixes two time values.
        frame_d = frame_q;
        if (ref_tc && slot_q == 3'd5) begin
            frame_d = {hrstens, hrsones, mintens, minones, sectens, secones};
        end

        sm_now      = {switch, mode};
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_vis_d = blink_vis_q;
        if (sm_now != sm_prev_q) begin
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_vis_d = ~blink_vis_q;
        end
    end

    always_comb begin
        case (slot_q)
            3'd0:    digit = frame_q[0];
            3'd1:    digit = frame_q[1];
            3'd2:    digit = frame_q[2];
            3'd3:    digit = frame_q[3];
            3'd4:    digit = frame_q[4];
            3'd5:    digit = frame_q[5];
            default: digit = 4'd0;
        endcase
        case (digit)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h3F;
        endcase

        // Edited pair index is mode-1: mode 1 -> slots 0/1, 2 -> 2/3, 3 -> 4/5.
        edit_hit   = (mode != 2'd0) && (slot_q[2:1] == (mode - 2'd1));
        edit_blank = !switch && edit_hit && !blink_vis_q;
        in_blank   = (ref_cnt_q < RW'(BLANK_CYC));

        an_d  = in_blank ? 8'hFF : ~(8'd1 << slot_q);
        seg_d = (in_blank || edit_blank) ? 7'h7F : dec;
        dp_d  = in_blank ? 1'b1 : !(slot_q == 3'd2 || slot_q == 3'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q   <= '0;
            slot_q      <= 3'd0;
            frame_q     <= '0;
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
            sm_prev_q   <= 3'b100;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            ref_cnt_q   <= ref_cnt_d;
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
            sm_prev_q   <= sm_now;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
        end
    end
endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: fixed vector tables for scan/tearing/blink/reset plus a randomized run against a cycle-count model.
module tb_seg_display_scan;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int BD = 16;

    typedef struct {
        int         n;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode;
    logic       switch;
    logic [3:0] hrstens, hrsones, mintens, minones, sectens, secones;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    seg_display_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .switch(switch),
        .hrstens(hrstens), .hrsones(hrsones), .mintens(mintens),
        .minones(minones), .sectens(sectens), .secones(secones),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: posedges since reset release, posedge of last {switch,mode} change, displayed frame.
    int         n;
    int         m_last;
    logic [3:0] mf [6];
    logic [2:0] prev_sm;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    vec_t scan_tbl  [16];
    vec_t blink_tbl [7];

    function automatic logic [6:0] seven(input logic [3:0] v);
        return (v < 4'd10) ? pat[v] : 7'h3F;
    endfunction

    task automatic cmp(input string name, input logic [7:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        if ({an, seg, dp} !== {ea, es, ed}) begin
            errors++;
            $display("FAIL %s (n=%0d): got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     name, n, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic set_inputs(input logic [3:0] a, b, c, d, e, f);
        hrstens = a; hrsones = b; mintens = c; minones = d; sectens = e; secones = f;
    endtask

    task automatic step();
        int s, cnt, slot, vis, nn;
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        logic [2:0] sm;
        @(posedge clk);
        s    = n;
        cnt  = s % RD;
        slot = (s / RD) % 6;
        vis  = 1 ^ (((s - m_last) / BD) % 2);
        sm   = {switch, mode};
        if (cnt < BC) begin
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
        end else begin
            ea = 8'hFF & ~(8'd1 << slot);
            ed = !(slot == 2 || slot == 4);
            if (!switch && mode != 2'd0 && (slot / 2) == int'(mode) - 1 && vis == 0)
                es = 7'h7F;
            else
                es = seven(mf[slot]);
        end
        nn = n + 1;
        if (nn % (RD * 6) == 0)
            mf = '{secones, sectens, minones, mintens, hrsones, hrstens};
        if (sm != prev_sm)
            m_last = nn;
        prev_sm = sm;
        n = nn;
        #1;
        cmp("model", ea, es, ed);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        cmp("reset_async", 8'hFF, 7'h7F, 1'b1);
        n = 0;
        m_last = 0;
        mf = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        prev_sm = 3'b100;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_hold", 8'hFF, 7'h7F, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic check_at(input int target, input logic [7:0] ea, input logic [6:0] es,
                            input logic ed, input string name);
        while (n < target) step();
        cmp(name, ea, es, ed);
    endtask

    initial begin
        scan_tbl = '{
            '{1,  8'hFF, 7'h7F, 1'b1}, '{2,  8'hFE, 7'h40, 1'b1},
            '{6,  8'hFD, 7'h40, 1'b1}, '{10, 8'hFB, 7'h40, 1'b0},
            '{25, 8'hFF, 7'h7F, 1'b1}, '{26, 8'hFE, 7'h02, 1'b1},
            '{30, 8'hFD, 7'h12, 1'b1}, '{34, 8'hFB, 7'h19, 1'b0},
            '{38, 8'hF7, 7'h30, 1'b1}, '{42, 8'hEF, 7'h24, 1'b0},
            '{46, 8'hDF, 7'h79, 1'b1}, '{47, 8'hDF, 7'h79, 1'b1},
            '{50, 8'hFE, 7'h10, 1'b1}, '{58, 8'hFB, 7'h19, 1'b0},
            '{62, 8'hF7, 7'h30, 1'b1}, '{82, 8'hFB, 7'h3F, 1'b0}
        };
        blink_tbl = '{
            '{34, 8'hFB, 7'h19, 1'b0}, '{50, 8'hFE, 7'h02, 1'b1},
            '{58, 8'hFB, 7'h7F, 1'b0}, '{62, 8'hF7, 7'h7F, 1'b1},
            '{66, 8'hEF, 7'h24, 1'b0}, '{82, 8'hFB, 7'h19, 1'b0},
            '{90, 8'hEF, 7'h7F, 1'b0}
        };

        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        switch = 1'b1;
        mode   = 2'd0;
        n = 0; m_last = 0; prev_sm = 3'b100;
        mf = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        #2;
        do_reset();

        // Scan order, frame latching (secones changes at slot 3, minones goes invalid mid-frame).
        foreach (scan_tbl[i]) begin
            while (n < scan_tbl[i].n) begin
                step();
                if (n == 36) secones = 4'd9;
                if (n == 52) minones = 4'hC;
            end
            cmp($sformatf("scan@%0d", scan_tbl[i].n), scan_tbl[i].an, scan_tbl[i].seg, scan_tbl[i].dp);
        end

        // Minutes edit blink, then switch to hours edit at n=62.
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        switch = 1'b1;
        mode   = 2'd0;
        do_reset();
        switch = 1'b0;
        mode   = 2'd2;
        foreach (blink_tbl[i]) begin
            while (n < blink_tbl[i].n) begin
                step();
                if (n == 62) mode = 2'd3;
            end
            cmp($sformatf("blink@%0d", blink_tbl[i].n), blink_tbl[i].an, blink_tbl[i].seg, blink_tbl[i].dp);
        end

        // Reset asserted at slot 3, count 2, then scan restarts from slot 0 with zeros.
        switch = 1'b1;
        mode   = 2'd0;
        do_reset();
        check_at(14, 8'hF7, 7'h40, 1'b1, "pre_reset_slot3");
        do_reset();
        check_at(1, 8'hFF, 7'h7F, 1'b1, "post_reset_blank");
        check_at(2, 8'hFE, 7'h40, 1'b1, "post_reset_zero");

        repeat (3000) begin
            step();
            if ($urandom_range(0, 7) == 0) hrstens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) hrsones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mintens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) minones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) sectens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) secones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                switch = 1'($urandom_range(0, 1));
                mode   = 2'($urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
